// File: rtl/siren_trigger_pkg.sv
// Shared constants for the siren trigger block: state encoding and the board
// clock from which the default debounce, on-time and holdoff counts derive.
package siren_trigger_pkg;

    localparam int CLK_HZ = 25_000_000;

    // 10 ms debounce, 10 s maximum on-time, 1 s holdoff at the board clock
    localparam int DEF_DEB_CYCLES  = CLK_HZ / 100;
    localparam int DEF_ON_CYCLES   = CLK_HZ * 10;
    localparam int DEF_HOLD_CYCLES = CLK_HZ;
    localparam int DEF_CNT_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOUND = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/siren_trigger_btn_debounce.sv
// Push-button conditioning: two-flop synchroniser, stability-count debounce
// and a registered one-cycle pulse on each debounced 0->1 transition.
module btn_debounce
    import siren_trigger_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_levelD;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Any return to the current level restarts the count, so short glitches never flip it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == DEB_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_levelD <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_levelD <= r_level;
            r_rise   <= r_level & ~r_levelD;
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_rise;

endmodule

// File: rtl/siren_trigger.sv
// Siren enable control: debounced button or external trigger starts a timed
// sounding period, followed by a holdoff during which restarts are ignored.
module siren_trigger
    import siren_trigger_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int ON_CYCLES   = DEF_ON_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       ext_trig,
    output logic       onoff,
    output logic [1:0] state,
    output logic       press
);

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             w_level_unused;
    logic             w_press;
    logic             w_start;
    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timerNext;
    logic             r_onoff;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .level      (w_level_unused),
        .rise_pulse (w_press)
    );

    assign w_start = w_press | ext_trig;

    // Timeout is tested before manual cancel so a coincident press still lands in holdoff
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        case (r_state)
            ST_IDLE: begin
                w_timerNext = '0;
                if (w_start) begin
                    w_stateNext = ST_SOUND;
                end
            end
            ST_SOUND: begin
                if (r_timer == ON_LAST) begin
                    w_stateNext = ST_HOLD;
                    w_timerNext = '0;
                end else if (w_press) begin
                    w_stateNext = ST_IDLE;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_timer == HOLD_LAST) begin
                    w_stateNext = ST_IDLE;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_timerNext = '0;
            end
        endcase
    end

    // onoff is registered from the next state so it tracks SOUND exactly and never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_onoff <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_timer <= w_timerNext;
            r_onoff <= (w_stateNext == ST_SOUND);
        end
    end

    assign onoff = r_onoff;
    assign state = r_state;
    assign press = w_press;

endmodule

// File: doc/siren_trigger.md
Name: siren_trigger

Overview:
- Control stage directly upstream of the siren tone generator. Produces its `onoff` enable level from a raw push-button and an external trigger pulse.
- Debounces and edge-detects the button, then runs a small arm/sound/holdoff state machine.
- Auto-cancels sounding after a fixed on-time, then enforces a holdoff so the siren cannot be re-armed immediately.
- Runs in the 25 MHz board clock domain.

Parameters:
- DEB_CYCLES, 250000, cycles the synchronised button must be stable before the debounced level changes (10 ms @ 25 MHz).
- ON_CYCLES, 250000000, maximum cycles `onoff` stays high per activation (10 s).
- HOLD_CYCLES, 25000000, cycles after auto-timeout during which all start requests are ignored (1 s).
- CNT_W, 32, width of the debounce and timer counters. Must hold max(DEB_CYCLES, ON_CYCLES, HOLD_CYCLES).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  1  raw push-button, asynchronous, active-high, bouncy.
- ext_trig  in  1  synchronous single-cycle start request from other logic.
- onoff  out  1  enable to the siren tone generator; high while sounding.
- state  out  2  current FSM state: 0 IDLE, 1 SOUND, 2 HOLDOFF.
- press  out  1  one-cycle pulse on each debounced button press.

Behaviour:
- Reset (rst_n low, asynchronous): onoff=0, state=IDLE, press=0. All counters, synchroniser flops and the debounced level clear to 0. Release is taken synchronously at the next clk edge.
- Synchroniser: btn passes through 2 flops before any other use.
- Debounce:
  - Counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments.
  - When it reaches DEB_CYCLES-1, the debounced level takes the synchronised value and the counter clears.
  - A glitch shorter than DEB_CYCLES restarts the count and never changes the level.
- press: asserted for exactly one cycle, the cycle after the debounced level goes 0->1. Release (1->0) produces no pulse.
- Latency: a clean btn rising edge produces press at most 2+DEB_CYCLES+1 cycles later. onoff follows press/ext_trig by 1 cycle (registered).
- Request definition: start = press | ext_trig.
- FSM, single registered state:
  - IDLE: start -> SOUND, timer cleared. onoff=0.
  - SOUND: onoff=1, timer increments each cycle.
    - press -> IDLE (manual cancel).
    - Timer reaching ON_CYCLES-1 -> HOLDOFF, timer cleared.
    - ext_trig in SOUND is ignored; it does not extend or cancel.
  - HOLDOFF: onoff=0, timer increments. All start requests are ignored. Timer reaching HOLD_CYCLES-1 -> IDLE.
  - Encoding 3 is illegal and recovers to IDLE on the next cycle with onoff=0.
- Simultaneous events:
  - In SOUND, if press coincides with the ON timeout, the timeout wins and the next state is HOLDOFF.
  - In IDLE, press and ext_trig together count as a single start.
- onoff is a direct register output, glitch-free, and high only in SOUND.
- Timer comparisons are equality on CNT_W-bit unsigned values. Counters never wrap, because each is cleared on reaching its limit.
- Reset mid-SOUND drops onoff asynchronously to 0 in the same instant. After release, no holdoff applies (state=IDLE).

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_SOUND=2'd1, ST_HOLD=2'd2;
  - board clock constant CLK_HZ=25000000, from which the default cycle counts derive.
- Sub-module btn_debounce (parameters DEB_CYCLES and CNT_W; ports clk, rst_n, btn, level, rise_pulse) contains the synchroniser, debounce counter and rising-edge detector.
- siren_trigger instantiates btn_debounce and contains the FSM and timer.

Test Plan (bench overrides DEB_CYCLES=4, ON_CYCLES=20, HOLD_CYCLES=8):
- Reset: hold rst_n=0 with btn=1 and ext_trig pulsing -> onoff=0, state=0, press=0 throughout. After release with btn held high, press fires once after the debounce delay (≤7 cycles) and onoff=1 on the following cycle.
- Bounce: btn toggles every 2 cycles for 20 cycles, then stays 1 -> press fires exactly once, ≤7 cycles after btn settles. No press during bouncing.
- Auto-timeout: one ext_trig pulse in IDLE -> onoff high exactly 20 cycles, then state=2 for 8 cycles. An ext_trig and a press issued during HOLDOFF are ignored. Then state=0.
- Manual cancel: ext_trig, then a debounced press 10 cycles into SOUND -> onoff falls the cycle after press, state=0, no HOLDOFF.
- Coincidence: press timed to land on SOUND cycle 20 -> next state=2 (HOLDOFF), not 0.
- Async reset mid-SOUND: pull rst_n low between clock edges at SOUND cycle 5 -> onoff=0 immediately without waiting for a clk edge. After release, state=0 and a new ext_trig restarts a full 20-cycle SOUND.
